// File: rtl/half_adder_axis_operand_slot.sv
// One-deep operand holding slot for an AXI-Stream slave channel.
// Ready is simply "slot empty"; the owner frees the slot with clear_i.
module axis_operand_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] tdata_i,
  input  logic             tvalid_i,
  output logic             tready_o,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // clear only ever arrives while full, so it never competes with a capture
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (tvalid_i && !full_q) begin
      data_d = tdata_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign tready_o = ~full_q;
  assign data_o   = data_q;
  assign full_o   = full_q;

endmodule

// File: rtl/half_adder_axis.sv
// AXI-Stream 1-bit half adder: leaf cell of the unit-adder tree.
// state   | meaning
// EMPTY   | neither slot full
// PARTIAL | one slot full
// LOADED  | both slots full, result registers on the next edge (one cycle)
// RESULT  | m_tvalid high, slots stay full until the output handshake
module half_adder_axis #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] s_a_tdata,
  input  logic             s_a_tvalid,
  output logic             s_a_tready,
  input  logic [WIDTH-1:0] s_b_tdata,
  input  logic             s_b_tvalid,
  output logic             s_b_tready,
  output logic [WIDTH:0]   m_result_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  localparam int RW = WIDTH + 1;

  logic [WIDTH-1:0] a_data, b_data;
  logic             a_full, b_full;
  logic             handshake;
  logic             compute;
  logic [RW-1:0]    result_q, result_d;
  logic             valid_q, valid_d;

  assign handshake = valid_q & m_tready;
  assign compute   = a_full & b_full & ~valid_q;

  axis_operand_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk      (clk),
    .arst_n   (arst_n),
    .tdata_i  (s_a_tdata),
    .tvalid_i (s_a_tvalid),
    .tready_o (s_a_tready),
    .clear_i  (handshake),
    .data_o   (a_data),
    .full_o   (a_full)
  );

  axis_operand_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk      (clk),
    .arst_n   (arst_n),
    .tdata_i  (s_b_tdata),
    .tvalid_i (s_b_tvalid),
    .tready_o (s_b_tready),
    .clear_i  (handshake),
    .data_o   (b_data),
    .full_o   (b_full)
  );

  // result data is left untouched on handshake; it is don't-care once valid drops
  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    if (compute) begin
      result_d = {1'b0, a_data} + {1'b0, b_data};
      valid_d  = 1'b1;
    end else if (handshake) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign m_result_tdata = result_q;
  assign m_tvalid       = valid_q;

endmodule

// File: tb/tb_half_adder_axis.sv
// Directed bench for half_adder_axis with an expected-result queue.
module tb_half_adder_axis;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [0:0] s_a_tdata, s_b_tdata;
  logic       s_a_tvalid, s_b_tvalid;
  logic       s_a_tready, s_b_tready;
  logic [1:0] m_result_tdata;
  logic       m_tvalid;
  logic       m_tready;

  int         checks   = 0;
  int         failures = 0;
  logic [1:0] sb[$];

  half_adder_axis #(.WIDTH(1)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .s_a_tdata      (s_a_tdata),
    .s_a_tvalid     (s_a_tvalid),
    .s_a_tready     (s_a_tready),
    .s_b_tdata      (s_b_tdata),
    .s_b_tvalid     (s_b_tvalid),
    .s_b_tready     (s_b_tready),
    .m_result_tdata (m_result_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ha_model(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_pair(input logic a, input logic b);
    s_a_tdata = a; s_b_tdata = b;
    s_a_tvalid = 1'b1; s_b_tvalid = 1'b1;
    sb.push_back(ha_model(a, b));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (m_tvalid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, m_tvalid}, 32'd1);
  endtask

  task automatic pop_chk(input string tag);
    logic [1:0] exp;
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk(tag, {30'd0, m_result_tdata}, {30'd0, exp});
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, m_tvalid}, 32'd0);
    chk({tag, "_a_rdy"}, {31'd0, s_a_tready}, 32'd1);
    chk({tag, "_b_rdy"}, {31'd0, s_b_tready}, 32'd1);
  endtask

  initial begin
    logic [1:0] pats [3];
    pats[0] = 2'b10; pats[1] = 2'b01; pats[2] = 2'b00;

    arst_n = 1'b0;
    s_a_tdata = '0; s_b_tdata = '0;
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    m_tready = 1'b0;

    // reset then idle
    #9;
    chk_idle("rst");
    chk("rst_data", {30'd0, m_result_tdata}, 32'd0);
    cyc();
    arst_n = 1'b1;
    cyc();
    chk_idle("post_rst");

    // A=1, B=1 together, held under back-pressure
    drive_pair(1'b1, 1'b1);
    cyc();
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    chk("cap_a_rdy", {31'd0, s_a_tready}, 32'd0);
    chk("cap_b_rdy", {31'd0, s_b_tready}, 32'd0);
    chk("loaded_valid", {31'd0, m_tvalid}, 32'd0);
    cyc();
    chk("lat_valid", {31'd0, m_tvalid}, 32'd1);
    chk("lat_data", {30'd0, m_result_tdata}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
      chk("hold_data", {30'd0, m_result_tdata}, 32'd2);
      chk("hold_a_rdy", {31'd0, s_a_tready}, 32'd0);
    end
    m_tready = 1'b1;
    pop_chk("res_11");
    cyc();
    m_tready = 1'b0;
    chk_idle("hs_11");

    // remaining input patterns, accepted as soon as valid rises
    for (int p = 0; p < 3; p++) begin
      drive_pair(pats[p][1], pats[p][0]);
      cyc();
      s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
      m_tready = 1'b1;
      cyc();
      chk("pat_valid", {31'd0, m_tvalid}, 32'd1);
      pop_chk("pat_res");
      cyc();
      m_tready = 1'b0;
      chk_idle("pat_hs");
    end

    // staggered arrival: A first, B three cycles later
    s_a_tdata = 1'b1; s_a_tvalid = 1'b1;
    cyc();
    s_a_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stag_a_rdy", {31'd0, s_a_tready}, 32'd0);
      chk("stag_b_rdy", {31'd0, s_b_tready}, 32'd1);
      chk("stag_valid", {31'd0, m_tvalid}, 32'd0);
      if (i < 2) cyc();
    end
    s_b_tdata = 1'b1; s_b_tvalid = 1'b1;
    sb.push_back(ha_model(1'b1, 1'b1));
    cyc();
    s_b_tvalid = 1'b0;
    chk("stag_loaded", {31'd0, m_tvalid}, 32'd0);
    cyc();
    chk("stag_valid_up", {31'd0, m_tvalid}, 32'd1);
    pop_chk("stag_res");
    m_tready = 1'b1;
    cyc();
    m_tready = 1'b0;
    chk_idle("stag_hs");

    // back-pressure with new operands waiting
    drive_pair(1'b0, 1'b1);
    cyc();
    s_a_tdata = 1'b1; s_b_tdata = 1'b1;
    wait_valid("bp_wait");
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", {30'd0, m_result_tdata}, 32'd1);
      chk("bp_a_rdy", {31'd0, s_a_tready}, 32'd0);
      chk("bp_b_rdy", {31'd0, s_b_tready}, 32'd0);
      cyc();
    end
    m_tready = 1'b1;
    pop_chk("bp_res");
    cyc();
    m_tready = 1'b0;
    chk_idle("bp_hs");
    sb.push_back(ha_model(1'b1, 1'b1));
    cyc();
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    chk("bp_recap_a", {31'd0, s_a_tready}, 32'd0);
    chk("bp_recap_b", {31'd0, s_b_tready}, 32'd0);
    wait_valid("bp_wait2");
    pop_chk("bp_res2");
    m_tready = 1'b1;
    cyc();
    m_tready = 1'b0;
    chk_idle("bp_hs2");

    // asynchronous reset while a result is pending; that result is discarded
    s_a_tdata = 1'b1; s_b_tdata = 1'b0;
    s_a_tvalid = 1'b1; s_b_tvalid = 1'b1;
    cyc();
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    wait_valid("mid_wait");
    #2 arst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_data", {30'd0, m_result_tdata}, 32'd0);
    cyc();
    arst_n = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_idle("after_rst");
    end
    m_tready = 1'b0;

    // normal operation resumes after reset
    drive_pair(1'b0, 1'b1);
    cyc();
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    wait_valid("final_wait");
    pop_chk("final_res");
    m_tready = 1'b1;
    cyc();
    m_tready = 1'b0;
    chk_idle("final_hs");
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/half_adder_axis.md
Name: half_adder_axis

Overview:
- AXI-Stream-style 1-bit half adder, the leaf adder cell of the matrix-multiplier unit-adder tree.
- Accepts one operand on each of two independent slave streams (A, B) and holds both.
- Emits {carry, sum} on one master stream, then blocks further input until the result is accepted.

Parameters:
- WIDTH, 1, operand width in bits. Result width is WIDTH+1; only WIDTH=1 is the required configuration.

Ports:
- clk  input  1  system clock, all state on rising edge
- arst_n  input  1  reset; asynchronous and active-low
- s_a_tdata  input  WIDTH  operand A
- s_a_tvalid  input  1  operand A valid
- s_a_tready  output  1  operand A slot empty
- s_b_tdata  input  WIDTH  operand B
- s_b_tvalid  input  1  operand B valid
- s_b_tready  output  1  operand B slot empty
- m_result_tdata  output  WIDTH+1  result; bit1 = carry, bit0 = sum for WIDTH=1
- m_tvalid  output  1  result valid
- m_tready  input  1  downstream accepts result

Behaviour:
- Each operand channel has a holding register plus a full flag.
- Ready generation: s_x_tready = ~full_x, driven combinationally from the flag.
- Capture: at a rising edge with s_x_tvalid & s_x_tready, store s_x_tdata and set full_x.
- A and B are independent. They may arrive in the same cycle or in different cycles, in either order.
- Compute: at the first edge where full_a & full_b & ~m_tvalid, register m_result_tdata = a + b (zero-extended to WIDTH+1) and set m_tvalid.
- For WIDTH=1 this gives carry = a & b, sum = a ^ b.
- Latency: both operands captured at edge N give m_tvalid high after edge N+1.
- Output hold: while m_tvalid = 1 and m_tready = 0, m_result_tdata and m_tvalid stay stable. Both slot flags stay set, so both treadys stay low.
- Output handshake: at an edge with m_tvalid & m_tready, clear m_tvalid, full_a and full_b. Both treadys return high in the following cycle.
- No new operand is accepted in the handshake cycle, because tready is low then.
- Holding tvalid high on a slave channel after capture has no effect until the slot is freed. It is captured again once tready rises.
- m_tready while m_tvalid = 0 is ignored.
- m_result_tdata keeps its last value after the handshake. Downstream treats it as don't-care while m_tvalid = 0.
- Reset (arst_n = 0, any time, including mid-transaction): full_a = full_b = 0, operand registers = 0, m_result_tdata = 0, m_tvalid = 0.
- During reset and immediately after it, s_a_tready = s_b_tready = 1. Any pending operands or result are discarded.
- State summary:
  - EMPTY: neither slot full.
  - PARTIAL: one slot full.
  - LOADED: both slots full, result not yet valid. Lasts exactly one cycle.
  - RESULT: m_tvalid = 1.
  - Transition RESULT -> EMPTY happens only on the output handshake.

Decomposition:
- No shared package is needed. Result width WIDTH+1 is a localparam inside the module.
- One natural sub-module, axis_operand_slot (tdata/tvalid/tready, a clear input, held data and full outputs), instantiated twice for A and B.
- Adder and output register stay in the top module.

Test Plan:
- Reset then idle: arst_n low for 10 ns -> m_tvalid = 0, m_result_tdata = 00, both tready = 1.
- A=1, B=1 presented together with tvalid high -> both treadys drop after the capture edge. m_tvalid = 1 one edge later with m_result_tdata = 10. Holds until m_tready = 1 for one cycle, then m_tvalid = 0 and treadys = 1.
- A=1, B=0 -> m_result_tdata = 01. A=0, B=1 -> 01. A=0, B=0 -> 00. Each is accepted with m_tready asserted the same cycle m_tvalid rises.
- Staggered arrival: A=1 at cycle 0, B=1 at cycle 3 -> s_a_tready low from cycle 1 while s_b_tready stays high. Result 10 valid one edge after B is captured.
- Back-pressure: m_tready held 0 for 5 cycles with new valid inputs waiting -> result stable, treadys low, inputs not captured. On acceptance, the waiting inputs are captured the cycle after treadys rise.
- Reset while m_tvalid = 1 -> m_tvalid = 0 and treadys = 1 immediately (asynchronous). No stale result appears after reset release.
